bcd_count_ctrl: RTL and testbench

Sequencing controller for a two-digit BCD counter built from two cascaded 74160-style decade counter instances: units (lo) and tens (hi). It turns single-cycle start/stop/clear/preset commands into the counters' LD/EP/ET/D controls. It enforces a programmable modulus MOD_N by synchronous reload, and reports run, wrap and error status. It sits between the front-panel command logic and the counter datapath of the timer design.

---
 rtl/bcd_count_ctrl_if.sv | 28 ++
 rtl/bcd_count_ctrl.sv | 136 +++++++++++++
 tb/tb_bcd_count_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_count_ctrl_if.sv
// Command, status and counter-control bundle between the front-panel logic,
// the two-digit BCD counter datapath and bcd_count_ctrl.
interface bcd_count_ctrl_if;
  logic       start;
  logic       stop;
  logic       clr;
  logic       preset_we;
  logic [7:0] preset_val;
  logic [3:0] q_hi;
  logic [3:0] q_lo;
  logic       cnt_ld_n;
  logic       cnt_ep;
  logic       cnt_et;
  logic [7:0] cnt_d;
  logic       running;
  logic       wrap;
  logic       err;

  modport master (
    output start, stop, clr, preset_we, preset_val, q_hi, q_lo,
    input  cnt_ld_n, cnt_ep, cnt_et, cnt_d, running, wrap, err
  );

  modport slave (
    input  start, stop, clr, preset_we, preset_val, q_hi, q_lo,
    output cnt_ld_n, cnt_ep, cnt_et, cnt_d, running, wrap, err
  );
endinterface

// File: rtl/bcd_count_ctrl.sv
// Sequencing controller for two cascaded 74160-style decade counters: turns
// start/stop/clr/preset pulses into LD/EP/ET/D and enforces modulus MOD_N.
module bcd_count_ctrl #(
  parameter int unsigned MOD_N     = 60,
  parameter bit          WRAP_STOP = 1'b0
) (
  input logic             clk_i,
  input logic             rst_i,
  bcd_count_ctrl_if.slave bus
);

  localparam int unsigned T     = MOD_N - 1;
  localparam logic [7:0]  T_BCD = {4'(T / 10), 4'(T % 10)};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  state_t     state_q, state_d;
  logic [7:0] ld_data_q, ld_data_d;
  logic       ret_run_q, ret_run_d;
  logic       err_q, err_d;

  logic [7:0] q_s;
  logic       at_term_s;
  logic       preset_ok_s;
  logic       cnt_ld_n_s, cnt_ep_s, cnt_et_s, wrap_s;
  logic [7:0] cnt_d_s;

  // Packed BCD with legal nibbles orders like a plain unsigned byte.
  assign q_s         = {bus.q_hi, bus.q_lo};
  assign at_term_s   = !bcd_ok(q_s) || (q_s >= T_BCD);
  assign preset_ok_s = bcd_ok(bus.preset_val) && (bus.preset_val <= T_BCD);

  // Next-state decode: clr > preset_we > stop > start, else autonomous moves.
  always_comb begin
    state_d   = state_q;
    ld_data_d = ld_data_q;
    ret_run_d = ret_run_q;
    err_d     = 1'b0;
    if (bus.clr) begin
      ld_data_d = 8'h00;
      ret_run_d = (state_q == S_RUN);
      state_d   = S_LOAD;
    end else if (bus.preset_we && (state_q != S_DONE)) begin
      if (preset_ok_s) begin
        ld_data_d = bus.preset_val;
        ret_run_d = (state_q == S_RUN);
        state_d   = S_LOAD;
      end else begin
        err_d = 1'b1;
      end
    end else if (bus.stop && (state_q == S_RUN)) begin
      state_d = S_PAUSE;
    end else if (bus.start && ((state_q == S_IDLE) || (state_q == S_PAUSE))) begin
      state_d = S_RUN;
    end else if (bus.start && (state_q == S_DONE)) begin
      ld_data_d = 8'h00;
      ret_run_d = 1'b1;
      state_d   = S_LOAD;
    end else begin
      case (state_q)
        S_LOAD: state_d = ret_run_q ? S_RUN : S_PAUSE;
        S_RUN: begin
          if (at_term_s && WRAP_STOP) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Controller state; reset abandons any LOAD in progress.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      ld_data_q <= 8'h00;
      ret_run_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_data_q <= ld_data_d;
      ret_run_q <= ret_run_d;
      err_q     <= err_d;
    end
  end

  // Counter controls depend only on state, ld_data and the present count.
  always_comb begin
    cnt_ld_n_s = 1'b1;
    cnt_ep_s   = 1'b0;
    cnt_et_s   = 1'b0;
    cnt_d_s    = 8'h00;
    wrap_s     = 1'b0;
    case (state_q)
      S_LOAD: begin
        cnt_ld_n_s = 1'b0;
        cnt_d_s    = ld_data_q;
      end
      S_RUN: begin
        if (at_term_s) begin
          wrap_s = 1'b1;
          if (!WRAP_STOP) begin
            cnt_ld_n_s = 1'b0;
          end else begin
            cnt_ld_n_s = 1'b1;
          end
        end else begin
          cnt_ep_s = 1'b1;
          cnt_et_s = 1'b1;
        end
      end
      default: cnt_ld_n_s = 1'b1;
    endcase
  end

  assign bus.cnt_ld_n = cnt_ld_n_s;
  assign bus.cnt_ep   = cnt_ep_s;
  assign bus.cnt_et   = cnt_et_s;
  assign bus.cnt_d    = cnt_d_s;
  assign bus.wrap     = wrap_s;
  assign bus.running  = (state_q == S_RUN);
  assign bus.err      = err_q;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Bench for bcd_count_ctrl: two instances (MOD_N=60 wrapping, MOD_N=24 stopping)
// each closing the loop through a behavioural pair of cascaded 74160 counters.
module tb_bcd_count_ctrl;

  typedef logic [21:0] vec_t;
  typedef struct {
    string tag;
    bit    inst_b;
    vec_t  v;
  } exp_t;

  logic clk;
  logic rst;
  logic [7:0] qa, qb;
  exp_t sb[$];
  int n_cmp;
  int n_mis;

  bcd_count_ctrl_if bus_a();
  bcd_count_ctrl_if bus_b();

  bcd_count_ctrl #(.MOD_N(60), .WRAP_STOP(1'b0)) dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a));
  bcd_count_ctrl #(.MOD_N(24), .WRAP_STOP(1'b1)) dut_b (.clk_i(clk), .rst_i(rst), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two 74160 decades: tens ET is the units ripple carry.
  function automatic logic [7:0] cnt_next(input logic [7:0] q, input logic ld_n,
                                          input logic ep, input logic et, input logic [7:0] d);
    logic [3:0] hi, lo;
    hi = q[7:4];
    lo = q[3:0];
    if (!ld_n) return d;
    if (ep && et) begin
      if (lo == 4'd9) begin
        lo = 4'd0;
        hi = (hi == 4'd9) ? 4'd0 : hi + 4'd1;
      end else begin
        lo = lo + 4'd1;
      end
    end
    return {hi, lo};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) qa <= 8'h00;
    else     qa <= cnt_next(qa, bus_a.cnt_ld_n, bus_a.cnt_ep, bus_a.cnt_et, bus_a.cnt_d);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) qb <= 8'h00;
    else     qb <= cnt_next(qb, bus_b.cnt_ld_n, bus_b.cnt_ep, bus_b.cnt_et, bus_b.cnt_d);
  end

  assign bus_a.q_hi = qa[7:4];
  assign bus_a.q_lo = qa[3:0];
  assign bus_b.q_hi = qb[7:4];
  assign bus_b.q_lo = qb[3:0];

  function automatic vec_t pk(input logic [7:0] q, input logic ld_n, input logic ep,
                              input logic et, input logic [7:0] d, input logic run,
                              input logic wr, input logic er);
    return {q, ld_n, ep, et, d, run, wr, er};
  endfunction

  function automatic logic [7:0] bcd(input int v);
    logic [3:0] h, l;
    h = 4'(v / 10);
    l = 4'(v % 10);
    return {h, l};
  endfunction

  // Expected status while counting; term marks the wrapping (WRAP_STOP=0) terminal.
  function automatic vec_t v_run(input logic [7:0] q, input logic term);
    return term ? pk(q, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0)
                : pk(q, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
  endfunction

  function automatic vec_t v_idle(input logic [7:0] q);
    return pk(q, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic vec_t v_load(input logic [7:0] q, input logic [7:0] d);
    return pk(q, 1'b0, 1'b0, 1'b0, d, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic vec_t obs(input bit b);
    if (b) return pk(qb, bus_b.cnt_ld_n, bus_b.cnt_ep, bus_b.cnt_et, bus_b.cnt_d,
                     bus_b.running, bus_b.wrap, bus_b.err);
    return pk(qa, bus_a.cnt_ld_n, bus_a.cnt_ep, bus_a.cnt_et, bus_a.cnt_d,
              bus_a.running, bus_a.wrap, bus_a.err);
  endfunction

  task automatic push(input string tag, input bit b, input vec_t v);
    exp_t e;
    e.tag    = tag;
    e.inst_b = b;
    e.v      = v;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    vec_t o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.inst_b);
      n_cmp++;
      assert (o === e.v) else begin
        n_mis++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.v);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check();
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst = 1'b1;
    bus_a.start = 1'b0; bus_a.stop = 1'b0; bus_a.clr = 1'b0;
    bus_a.preset_we = 1'b0; bus_a.preset_val = 8'h00;
    bus_b.start = 1'b0; bus_b.stop = 1'b0; bus_b.clr = 1'b0;
    bus_b.preset_we = 1'b0; bus_b.preset_val = 8'h00;

    #2;
    push("reset_a", 1'b0, v_idle(8'h00));
    push("reset_b", 1'b1, v_idle(8'h00));
    check();
    @(posedge clk);
    #1;
    rst = 1'b0;
    push("idle_a", 1'b0, v_idle(8'h00));
    push("idle_b", 1'b1, v_idle(8'h00));
    step();

    // Free-running count through the 59 -> 00 wrap.
    bus_a.start = 1'b1;
    for (int i = 0; i < 62; i++) begin
      push("count60", 1'b0, v_run(bcd(i % 60), (i % 60) == 59));
      step();
      bus_a.start = 1'b0;
    end

    rst = 1'b1;
    #3;
    rst = 1'b0;
    push("rst_pulse", 1'b0, v_idle(8'h00));
    check();

    // Preset from IDLE parks in PAUSE.
    bus_a.preset_val = 8'h57;
    bus_a.preset_we = 1'b1;
    push("preset57_load", 1'b0, v_load(8'h00, 8'h57));
    step();
    bus_a.preset_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push("preset57_pause", 1'b0, v_idle(8'h57));
      step();
    end
    bus_a.start = 1'b1;
    push("resume57", 1'b0, v_run(8'h57, 1'b0));
    step();
    bus_a.start = 1'b0;
    push("run58", 1'b0, v_run(8'h58, 1'b0));
    step();
    push("run59_wrap", 1'b0, v_run(8'h59, 1'b1));
    step();
    bus_a.stop = 1'b1;
    push("stop_on_term", 1'b0, v_idle(8'h00));
    step();
    bus_a.stop = 1'b0;
    push("paused00", 1'b0, v_idle(8'h00));
    step();

    // Rejected presets, then the largest legal one.
    bus_a.start = 1'b1;
    push("restart00", 1'b0, v_run(8'h00, 1'b0));
    step();
    bus_a.start = 1'b0;
    bus_a.preset_val = 8'h5A;
    bus_a.preset_we = 1'b1;
    push("bad_nibble_err", 1'b0, pk(8'h01, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1));
    step();
    bus_a.preset_we = 1'b0;
    push("err_clears1", 1'b0, v_run(8'h02, 1'b0));
    step();
    bus_a.preset_val = 8'h60;
    bus_a.preset_we = 1'b1;
    push("over_t_err", 1'b0, pk(8'h03, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1));
    step();
    bus_a.preset_we = 1'b0;
    push("err_clears2", 1'b0, v_run(8'h04, 1'b0));
    step();
    bus_a.preset_val = 8'h59;
    bus_a.preset_we = 1'b1;
    push("preset_t_load", 1'b0, v_load(8'h05, 8'h59));
    step();
    bus_a.preset_we = 1'b0;
    push("preset_t_run", 1'b0, v_run(8'h59, 1'b1));
    step();
    push("preset_t_wrap", 1'b0, v_run(8'h00, 1'b0));
    step();

    for (int i = 1; i <= 22; i++) begin
      push("count_to22", 1'b0, v_run(bcd(i), 1'b0));
      step();
    end
    bus_a.stop = 1'b1;
    push("stop_at23", 1'b0, v_idle(8'h23));
    step();
    bus_a.stop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push("hold23", 1'b0, v_idle(8'h23));
      step();
    end
    bus_a.start = 1'b1;
    push("start_from23", 1'b0, v_run(8'h23, 1'b0));
    step();
    bus_a.start = 1'b0;
    for (int i = 24; i <= 41; i++) begin
      push("resume_count", 1'b0, v_run(bcd(i), 1'b0));
      step();
    end
    bus_a.clr = 1'b1;
    push("clr_load", 1'b0, v_load(8'h42, 8'h00));
    step();
    bus_a.clr = 1'b0;
    push("clr_q00", 1'b0, v_run(8'h00, 1'b0));
    step();
    push("clr_q01", 1'b0, v_run(8'h01, 1'b0));
    step();

    // clr beats preset_we and stop on the same edge.
    bus_a.clr = 1'b1;
    bus_a.preset_we = 1'b1;
    bus_a.preset_val = 8'h30;
    bus_a.stop = 1'b1;
    push("prio_load", 1'b0, v_load(8'h02, 8'h00));
    step();
    bus_a.clr = 1'b0;
    bus_a.preset_we = 1'b0;
    bus_a.stop = 1'b0;
    push("prio_q00", 1'b0, v_run(8'h00, 1'b0));
    step();
    push("prio_q01", 1'b0, v_run(8'h01, 1'b0));
    step();

    // Asynchronous reset in the middle of a LOAD cycle.
    bus_a.clr = 1'b1;
    push("mid_load", 1'b0, v_load(8'h02, 8'h00));
    step();
    bus_a.clr = 1'b0;
    rst = 1'b1;
    #2;
    push("rst_mid_load", 1'b0, v_idle(8'h00));
    check();
    rst = 1'b0;
    push("after_rst_idle", 1'b0, v_idle(8'h00));
    step();

    // Instance b: MOD_N=24 stop-at-terminal behaviour.
    bus_b.preset_val = 8'h24;
    bus_b.preset_we = 1'b1;
    push("b_preset_err", 1'b1, pk(8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
    step();
    bus_b.preset_we = 1'b0;
    push("b_err_clear", 1'b1, v_idle(8'h00));
    step();
    bus_b.start = 1'b1;
    for (int i = 0; i < 23; i++) begin
      push("b_count", 1'b1, v_run(bcd(i), 1'b0));
      step();
      bus_b.start = 1'b0;
    end
    push("b_term", 1'b1, pk(8'h23, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0));
    step();
    push("b_done", 1'b1, v_idle(8'h23));
    step();
    push("b_done_hold", 1'b1, v_idle(8'h23));
    step();
    bus_b.start = 1'b1;
    push("b_restart_load", 1'b1, v_load(8'h23, 8'h00));
    step();
    bus_b.start = 1'b0;
    push("b_restart_q00", 1'b1, v_run(8'h00, 1'b0));
    step();
    push("b_restart_q01", 1'b1, v_run(8'h01, 1'b0));
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
